// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg
//   Shared definitions for the UART transmit framing stage.
//   - tx_state_t          : transmitter state encoding (IDLE/START/DATA/PARITY/STOP)
//   - START_BIT, STOP_BIT : serial line levels for the framing bits
//   - IDLE_LEVEL          : line level while no frame is being sent
//   - DEFAULT_DATA_WIDTH  : default number of data bits per frame
package uart_tx_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 8;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

endpackage

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer
//   Shift register and bit counter for the UART transmitter.
//   Ports:
//     clk      in   baud-rate clock
//     rst      in   asynchronous active-high reset
//     load     in   capture data into the shift register, clear the counter
//     shift    in   shift right by one, advance the counter
//     data     in   parallel data word (DATA_WIDTH bits)
//     ser_data out  current LSB of the shift register
//     ser_done out  every data bit has been handed out (counter == DATA_WIDTH)
module uart_tx_serializer
    import uart_tx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  shift,
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  ser_data,
    output logic                  ser_done
);

    localparam int unsigned CW = $clog2(DATA_WIDTH + 1);

    logic [DATA_WIDTH-1:0] shift_reg;
    logic [CW-1:0]         bit_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else if (load) begin
            shift_reg <= data;
            bit_cnt   <= '0;
        end else if (shift) begin
            shift_reg <= shift_reg >> 1;
            bit_cnt   <= bit_cnt + CW'(1);
        end
    end

    assign ser_data = shift_reg[0];
    // The counter tracks bits already handed to the registered line driver,
    // so it reaches DATA_WIDTH while the last data bit is on the line.
    assign ser_done = (bit_cnt == CW'(DATA_WIDTH));

endmodule

// File: rtl/uart_tx_frame.sv
// uart_tx_frame
//   UART transmit framing stage: latches a byte, sends start bit, data bits
//   LSB-first, optional parity bit (from parity_calc) and stop bit(s), one
//   bit per clk.
//   Build option: define UART_TX_STOP2_EN for two stop bits (default one).
//   Ports:
//     clk        in   baud-rate clock
//     rst        in   asynchronous active-high reset
//     p_data     in   parallel data, sampled in the acceptance cycle
//     data_valid in   single-cycle send request, honoured only in IDLE
//     par_en     in   insert parity bit, latched at acceptance
//     par_bit    in   parity value, sampled on entry to PARITY
//     tx_out     out  registered serial line, idle high
//     busy       out  registered, high while a frame is on the line
//     frame_done out  registered one-cycle pulse after the last stop bit
module uart_tx_frame
    import uart_tx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  data_valid,
    input  logic                  par_en,
    input  logic                  par_bit,
    output logic                  tx_out,
    output logic                  busy,
    output logic                  frame_done
);

`ifdef UART_TX_STOP2_EN
    localparam bit STOP2 = 1'b1;
`else
    localparam bit STOP2 = 1'b0;
`endif

    tx_state_t state, state_next;
    logic      tx_next, busy_next, done_next;
    logic      par_en_q, par_en_next;
    logic      stop_second, stop_second_next;
    logic      load, shift;
    logic      ser_data, ser_done;

    uart_tx_serializer #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_serializer (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .shift   (shift),
        .data    (p_data),
        .ser_data(ser_data),
        .ser_done(ser_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            tx_out      <= IDLE_LEVEL;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            par_en_q    <= 1'b0;
            stop_second <= 1'b0;
        end else begin
            state       <= state_next;
            tx_out      <= tx_next;
            busy        <= busy_next;
            frame_done  <= done_next;
            par_en_q    <= par_en_next;
            stop_second <= stop_second_next;
        end
    end

    // Outputs are registered from the next-state decision, so tx_out always
    // shows the bit belonging to the current state.
    always_comb begin
        state_next       = state;
        tx_next          = IDLE_LEVEL;
        busy_next        = 1'b0;
        done_next        = 1'b0;
        par_en_next      = par_en_q;
        stop_second_next = 1'b0;
        load             = 1'b0;
        shift            = 1'b0;

        case (state)
            IDLE: begin
                if (data_valid) begin
                    load        = 1'b1;
                    par_en_next = par_en;
                    state_next  = START;
                    tx_next     = START_BIT;
                    busy_next   = 1'b1;
                end
            end
            START: begin
                shift      = 1'b1;
                tx_next    = ser_data;
                busy_next  = 1'b1;
                state_next = DATA;
            end
            DATA: begin
                busy_next = 1'b1;
                if (ser_done) begin
                    if (par_en_q) begin
                        state_next = PARITY;
                        tx_next    = par_bit;
                    end else begin
                        state_next = STOP;
                        tx_next    = STOP_BIT;
                    end
                end else begin
                    shift   = 1'b1;
                    tx_next = ser_data;
                end
            end
            PARITY: begin
                state_next = STOP;
                tx_next    = STOP_BIT;
                busy_next  = 1'b1;
            end
            STOP: begin
                if (STOP2 && !stop_second) begin
                    stop_second_next = 1'b1;
                    tx_next          = STOP_BIT;
                    busy_next        = 1'b1;
                end else begin
                    state_next = IDLE;
                    tx_next    = IDLE_LEVEL;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
module tb_uart_tx_frame;

    localparam int DW = 8;
`ifdef UART_TX_STOP2_EN
    localparam int NSTOP = 2;
`else
    localparam int NSTOP = 1;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] p_data;
    logic          data_valid;
    logic          par_en;
    logic          par_bit;
    logic          tx_out;
    logic          busy;
    logic          frame_done;

    int n_checks = 0;
    int n_fail   = 0;
    bit exp_q[$];

    uart_tx_frame #(
        .DATA_WIDTH(DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .p_data    (p_data),
        .data_valid(data_valid),
        .par_en    (par_en),
        .par_bit   (par_bit),
        .tx_out    (tx_out),
        .busy      (busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference frame: the line levels of one whole frame, cycle by cycle.
    function automatic void build_frame(input logic [DW-1:0] d, input logic pe, input logic pb);
        exp_q.delete();
        exp_q.push_back(1'b0);
        for (int i = 0; i < DW; i++) exp_q.push_back(d[i]);
        if (pe) exp_q.push_back(pb);
        for (int i = 0; i < NSTOP; i++) exp_q.push_back(1'b1);
    endfunction

    task automatic chk_idle(input string tag, input logic done_exp);
        chk({tag, "_tx"}, tx_out, 1'b1);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, frame_done, done_exp);
    endtask

    // Called at a negedge with the line idle. poke_at >= 0 raises data_valid
    // with 0xFF during that frame cycle; noise scrambles p_data/par_en mid-frame.
    task automatic send_frame(input logic [DW-1:0] d, input logic pe, input logic pb,
                              input int poke_at, input bit noise);
        int w;
        p_data     = d;
        par_en     = pe;
        par_bit    = pb;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        w = 0;
        while (tx_out !== 1'b0 && w < 3) begin
            @(negedge clk);
            w++;
        end
        build_frame(d, pe, pb);
        for (int i = 0; i < exp_q.size(); i++) begin
            chk("frame_tx", tx_out, exp_q[i]);
            chk("frame_busy", busy, 1'b1);
            chk("frame_done_low", frame_done, 1'b0);
            if (noise) begin
                p_data = DW'($urandom);
                par_en = 1'($urandom);
            end
            if (i == poke_at) begin
                data_valid = 1'b1;
                p_data     = '1;
            end else begin
                data_valid = 1'b0;
            end
            @(negedge clk);
        end
        data_valid = 1'b0;
        chk_idle("end", 1'b1);
        @(negedge clk);
        chk_idle("after", 1'b0);
    endtask

    initial begin
        rst        = 1'b1;
        data_valid = 1'b0;
        p_data     = '0;
        par_en     = 1'b0;
        par_bit    = 1'b0;
        repeat (2) @(negedge clk);
        chk_idle("reset", 1'b0);
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk_idle("idle", 1'b0);
        end

        // Plain frame, then framed with parity
        send_frame(8'hA5, 1'b0, 1'b0, -1, 1'b0);
        send_frame(8'hA5, 1'b1, 1'b0, -1, 1'b0);

        // Request during a frame is dropped
        send_frame(8'hA5, 1'b1, 1'b1, 3, 1'b0);
        repeat (4) begin
            @(negedge clk);
            chk_idle("no_second", 1'b0);
        end

        // data_valid held: exactly one idle-high cycle between frames
        p_data     = '0;
        par_en     = 1'b0;
        data_valid = 1'b1;
        @(negedge clk);
        build_frame('0, 1'b0, 1'b0);
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < exp_q.size(); i++) begin
                chk("b2b_tx", tx_out, exp_q[i]);
                chk("b2b_busy", busy, 1'b1);
                @(negedge clk);
            end
            chk_idle("b2b_gap", 1'b1);
            if (f == 2) data_valid = 1'b0;
            @(negedge clk);
        end
        chk_idle("b2b_end", 1'b0);

        // Reset during data bit 4 (0xEF has bit 4 = 0)
        p_data     = 8'hEF;
        par_en     = 1'b1;
        par_bit    = 1'b1;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        chk("rst_start", tx_out, 1'b0);
        repeat (5) @(negedge clk);
        chk("rst_bit4", tx_out, 1'b0);
        #2 rst = 1'b1;
        #1 chk_idle("rst_async", 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) begin
            @(negedge clk);
            chk_idle("rst_after", 1'b0);
        end
        send_frame(8'h3C, 1'b0, 1'b0, -1, 1'b0);
        send_frame(8'h3C, 1'b1, 1'b1, -1, 1'b0);

        // Randomized frames with mid-frame input noise
        repeat (20) begin
            send_frame(DW'($urandom), 1'($urandom), 1'($urandom), -1, 1'b1);
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                chk_idle("gap", 1'b0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
